// File: rtl/vproc_pkg.sv
// Shared opcode and FSM state encodings plus instruction field layout for vproc_core.
package vproc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_STORE = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_MUL   = 3'b100,
    OP_NOP   = 3'b101,
    OP_ILL6  = 3'b110,
    OP_ILL7  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_MEM_WAIT
  } state_e;

  // Instruction word, MSB first: {op, rd, rs1, rs2, addr}
  function automatic int rd_lsb(input int ra, input int aw);
    return 2 * ra + aw;
  endfunction

  function automatic int rs1_lsb(input int ra, input int aw);
    return ra + aw;
  endfunction

  function automatic int rs2_lsb(input int ra, input int aw);
    return ra + 0 * aw + aw - ra;
  endfunction

endpackage

// File: rtl/vproc_lane_alu.sv
// One EW-bit lane of the vector adder/subtractor, combinational.
// VPROC_SAT_EN selects signed saturation instead of modulo-2^EW wrap.
module vproc_lane_alu #(
  parameter int EW = 32
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic          sub,
  output logic [EW-1:0] y
);

`ifdef VPROC_SAT_EN
  function automatic logic [EW-1:0] sat(input logic signed [EW:0] s);
    // Overflow shows up as the two top bits of the widened result disagreeing.
    if (s[EW] != s[EW-1])
      return s[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
    else
      return s[EW-1:0];
  endfunction

  logic signed [EW:0] sa, sb, s;

  always_comb begin
    sa = {a[EW-1], a};
    sb = {b[EW-1], b};
    s  = sub ? (sa - sb) : (sa + sb);
    y  = sat(s);
  end
`else
  always_comb begin
    y = sub ? (a - b) : (a + b);
  end
`endif

endmodule

// File: rtl/vproc_core.sv
// Vector core: NREG x (EW*LANES) register file, lane-wise add/sub/mul and a handshaked memory port.
// Optional build macro VPROC_SAT_EN makes ADD/SUB saturate per lane.
module vproc_core
  import vproc_pkg::*;
#(
  parameter int  NREG  = 4,
  parameter int  EW    = 32,
  parameter int  LANES = 16,
  parameter int  AW    = 9,
  localparam int RA    = $clog2(NREG),
  localparam int VLEN  = EW * LANES,
  localparam int IW    = OP_W + 3 * RA + AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [IW-1:0]   instr,
  output logic            done,
  output logic            err,
  output logic            zero,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [VLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [VLEN-1:0] mem_rdata,
  input  logic [RA-1:0]   dbg_sel,
  output logic [VLEN-1:0] dbg_data
);

  localparam int             CW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(LANES - 1);
  localparam int             RD_LSB  = rd_lsb(RA, AW);
  localparam int             RS1_LSB = rs1_lsb(RA, AW);
  localparam int             RS2_LSB = rs2_lsb(RA, AW);

  state_e            state_p0, state_d;
  op_e               op_in, op_p0;
  logic [RA-1:0]     rd_in, rs1_in, rs2_in, rd_p0;
  logic [AW-1:0]     addr_p0;
  logic [VLEN-1:0]   opa_p0, opb_p0;
  logic [VLEN-1:0]   regs [NREG];
  logic [CW-1:0]     cnt_p1;
  logic [VLEN-1:0]   lo_p1, hi_p1, lo_d, hi_d;
  logic [VLEN-1:0]   alu_y;
  logic [EW-1:0]     a_lane, b_lane;
  logic [2*EW-1:0]   prod;
  logic              zero_p, accept, illegal;

  assign op_in  = op_e'(instr[IW-1 -: OP_W]);
  assign rd_in  = instr[RD_LSB +: RA];
  assign rs1_in = instr[RS1_LSB +: RA];
  assign rs2_in = instr[RS2_LSB +: RA];

  assign illegal   = (op_p0 == OP_ILL6) || (op_p0 == OP_ILL7);
  assign mem_req   = (state_p0 == S_MEM_WAIT);
  assign mem_we    = (op_p0 == OP_STORE);
  assign mem_addr  = addr_p0;
  assign mem_wdata = opa_p0;
  assign dbg_data  = regs[dbg_sel];
  assign zero      = zero_p;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vproc_lane_alu #(.EW(EW)) u_alu (
      .a   (opa_p0[l*EW +: EW]),
      .b   (opb_p0[l*EW +: EW]),
      .sub (op_p0 == OP_SUB),
      .y   (alu_y[l*EW +: EW])
    );
  end

  // Single multiplier, stepped across lanes by cnt_p1; products collect in lo/hi.
  always_comb begin
    a_lane = opa_p0[cnt_p1*EW +: EW];
    b_lane = opb_p0[cnt_p1*EW +: EW];
    prod   = {{EW{1'b0}}, a_lane} * {{EW{1'b0}}, b_lane};
    lo_d   = lo_p1;
    hi_d   = hi_p1;
    lo_d[cnt_p1*EW +: EW] = prod[EW-1:0];
    hi_d[cnt_p1*EW +: EW] = prod[2*EW-1:EW];
  end

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= S_IDLE;
    else     state_p0 <= state_d;
  end

  always_comb begin
    state_d     = state_p0;
    instr_ready = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_p0)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && !rst) begin
          accept = 1'b1;
          case (op_in)
            OP_STORE, OP_LOAD: state_d = S_MEM_WAIT;
            OP_MUL:            state_d = S_MUL;
            default:           state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        done    = 1'b1;
        err     = illegal;
        state_d = S_IDLE;
      end
      S_MUL: begin
        if (cnt_p1 == LAST) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset aborts the instruction in flight without retiring it.
    if (rst) begin
      done = 1'b0;
      err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      op_p0   <= OP_NOP;
      rd_p0   <= '0;
      addr_p0 <= '0;
      opa_p0  <= '0;
      opb_p0  <= '0;
      cnt_p1  <= '0;
      lo_p1   <= '0;
      hi_p1   <= '0;
      zero_p  <= 1'b0;
    end else begin
      // Accept stage: snapshot fields and operands so rd may alias rs1/rs2.
      if (accept) begin
        op_p0   <= op_in;
        rd_p0   <= rd_in;
        addr_p0 <= instr[AW-1:0];
        opa_p0  <= regs[rs1_in];
        opb_p0  <= regs[rs2_in];
        cnt_p1  <= '0;
      end
      if (state_p0 == S_EXEC && (op_p0 == OP_ADD || op_p0 == OP_SUB)) begin
        regs[rd_p0] <= alu_y;
        zero_p      <= (alu_y == '0);
      end
      // Lane-serial multiply stage; high half wraps into register 0 past the top.
      if (state_p0 == S_MUL) begin
        cnt_p1 <= cnt_p1 + CW'(1);
        lo_p1  <= lo_d;
        hi_p1  <= hi_d;
        if (cnt_p1 == LAST) begin
          regs[rd_p0]             <= lo_d;
          regs[rd_p0 + RA'(1)]    <= hi_d;
          zero_p                  <= (lo_d == '0) && (hi_d == '0);
        end
      end
      if (state_p0 == S_MEM_WAIT && mem_ack && op_p0 == OP_LOAD)
        regs[rd_p0] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vproc_core.sv
// Randomised self-checking bench for vproc_core (NREG=4, EW=8, LANES=4) against a lane-level model.
module tb_vproc_core;

  localparam int NREG = 4, EW = 8, LANES = 4, AW = 9;
  localparam int VLEN = EW * LANES;

  logic            clk = 1'b0;
  logic            rst, instr_valid, instr_ready;
  logic [17:0]     instr;
  logic            done, err, zero, mem_req, mem_we, mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [VLEN-1:0] mem_wdata, mem_rdata, dbg_data;
  logic [1:0]      dbg_sel;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] rm [NREG];
  logic        zm;

  always #5 clk = ~clk;

  vproc_core #(.NREG(NREG), .EW(EW), .LANES(LANES), .AW(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .done(done), .err(err), .zero(zero), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane model: each lane is an independent 8-bit integer.
  function automatic logic [31:0] m_addsub(input logic [31:0] a, input logic [31:0] b, input bit sub);
    logic [31:0] r;
    logic [7:0] al, bl;
    logic signed [7:0] sal, sbl;
    int x;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      al = a[l*8 +: 8];
      bl = b[l*8 +: 8];
`ifdef VPROC_SAT_EN
      sal = al;
      sbl = bl;
      x = sub ? (int'(sal) - int'(sbl)) : (int'(sal) + int'(sbl));
      if (x > 127) x = 127;
      if (x < -128) x = -128;
`else
      x = sub ? (int'(al) - int'(bl)) : (int'(al) + int'(bl));
      x = x & 255;
`endif
      r[l*8 +: 8] = x[7:0];
    end
    return r;
  endfunction

  function automatic void m_mul(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi);
    int p;
    lo = '0;
    hi = '0;
    for (int l = 0; l < LANES; l++) begin
      p = int'(a[l*8 +: 8]) * int'(b[l*8 +: 8]);
      lo[l*8 +: 8] = p[7:0];
      hi[l*8 +: 8] = p[15:8];
    end
  endfunction

  task automatic read_reg(input logic [1:0] sel, output logic [31:0] v);
    dbg_sel = sel;
    #1;
    v = dbg_data;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    for (int i = 0; i < NREG; i++) begin
      read_reg(2'(i), v);
      chk($sformatf("%s_r%0d", tag, i), v, rm[i]);
    end
    chk({tag, "_zero"}, zero, zm);
    chk({tag, "_ready"}, instr_ready, 1);
  endtask

  // Issue one instruction at a negedge in IDLE and run it to retirement.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [8:0] addr, input int lat,
                       input logic [31:0] rdata);
    int cyc, reqc, exp_cyc;
    bit got, is_mem;
    logic [31:0] lo, hi;
    is_mem  = (op == 3'd0) || (op == 3'd1);
    exp_cyc = is_mem ? lat : ((op == 3'd4) ? LANES : 1);
    chk("accept_ready", instr_ready, 1);
    instr = {op, rd, rs1, rs2, addr};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    cyc = 0; reqc = 0; got = 0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      chk("busy_ready", instr_ready, 0);
      if (mem_req) begin
        reqc++;
        chk("mem_we", mem_we, (op == 3'd0));
        chk("mem_addr", mem_addr, addr);
        if (op == 3'd0) chk("mem_wdata", mem_wdata, rm[rs1]);
        if (reqc == lat) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      #1;
      if (done) begin
        got = 1;
        chk("done_cycle", cyc, exp_cyc);
        chk("err", err, (op >= 3'd6));
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    if (!got) chk("timeout", 0, 1);
    chk("req_cycles", reqc, is_mem ? lat : 0);
    case (op)
      3'd1: rm[rd] = rdata;
      3'd2, 3'd3: begin
        rm[rd] = m_addsub(rm[rs1], rm[rs2], op == 3'd3);
        zm = (rm[rd] == 0);
      end
      3'd4: begin
        m_mul(rm[rs1], rm[rs2], lo, hi);
        rm[rd] = lo;
        rm[(rd + 1) % NREG] = hi;
        zm = (lo == 0) && (hi == 0);
      end
      default: ;
    endcase
    @(negedge clk);
    chk("req_drop", mem_req, 0);
    chk("done_once", done, 0);
    check_state("post");
  endtask

  initial begin
    logic [31:0] v, lo, hi;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0; mem_rdata = '0; dbg_sel = '0;
    for (int i = 0; i < NREG; i++) rm[i] = '0;
    zm = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    check_state("rst");

    // Acknowledge with no request outstanding must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk("spurious_done", done, 0);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check_state("spurious");

    issue(3'd1, 2'd1, 2'd0, 2'd0, 9'd5, 3, 32'h04030201);
    read_reg(2'd1, v); chk("t1_r1", v, 32'h04030201);

    issue(3'd1, 2'd1, 2'd0, 2'd0, 9'd9, 1, 32'h7F80FF01);
    issue(3'd2, 2'd2, 2'd1, 2'd1, 9'd0, 1, 0);
    read_reg(2'd2, v);
`ifdef VPROC_SAT_EN
    chk("t2_r2", v, 32'h7F80FE02);
`else
    chk("t2_r2", v, 32'hFE00FE02);
`endif
    chk("t2_zero", zero, 0);

    issue(3'd1, 2'd0, 2'd0, 2'd0, 9'd1, 2, 32'h02FF0310);
    issue(3'd1, 2'd1, 2'd0, 2'd0, 9'd2, 1, 32'h02FF0310);
    issue(3'd4, 2'd3, 2'd0, 2'd1, 9'd0, 1, 0);
    read_reg(2'd3, v); chk("t3_lo", v, 32'h04010900);
    read_reg(2'd0, v); chk("t3_hi_wrap", v, 32'h00FE0001);

    issue(3'd3, 2'd2, 2'd1, 2'd1, 9'd0, 1, 0);
    chk("t4_zero", zero, 1);
    issue(3'd0, 2'd0, 2'd2, 2'd0, 9'd7, 2, 0);
    chk("t4_zero_kept", zero, 1);

    issue(3'd7, 2'd1, 2'd2, 2'd3, 9'd4, 1, 0);
    issue(3'd6, 2'd0, 2'd0, 2'd0, 9'd0, 1, 0);
    issue(3'd5, 2'd0, 2'd0, 2'd0, 9'd0, 1, 0);

    // MUL with the next instruction already offered: it must wait for retirement.
    instr = {3'd4, 2'd2, 2'd0, 2'd1, 9'd0};
    instr_valid = 1'b1;
    chk("t6_ready", instr_ready, 1);
    @(posedge clk);
    #1 instr = {3'd5, 2'd0, 2'd0, 2'd0, 9'd0};
    for (int c = 1; c <= LANES; c++) begin
      @(negedge clk);
      chk("t6_hold_ready", instr_ready, 0);
      #1 chk("t6_mul_done", done, (c == LANES));
      @(posedge clk);
      #1;
    end
    m_mul(rm[0], rm[1], lo, hi);
    rm[2] = lo; rm[3] = hi; zm = (lo == 0) && (hi == 0);
    @(negedge clk);
    chk("t6_next_ready", instr_ready, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("t6_nop_done", done, 1);
    chk("t6_nop_err", err, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_state("t6");

    for (int k = 0; k < 60; k++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 9'($urandom), int'($urandom_range(1, 4)), $urandom);
    end

    // Reset in MEM_WAIT, with an ack arriving in the same cycle.
    instr = {3'd1, 2'd1, 2'd0, 2'd0, 9'd3};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("t5_req", mem_req, 1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1 chk("t5_no_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < NREG; i++) rm[i] = '0;
    zm = 1'b0;
    @(negedge clk);
    chk("t5_req_drop", mem_req, 0);
    chk("t5_done", done, 0);
    check_state("t5");
    issue(3'd2, 2'd0, 2'd1, 2'd2, 9'd0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
